// File: rtl/median_pkg.sv
// median_pkg: state type and sizing helpers shared by the median filter datapath.
package median_pkg;
  localparam int MEDIAN_DATA_WIDTH = 8;
  typedef enum logic [1:0] {FILL, PRE, BODY, POST} feeder_state_t;
  function automatic int halo(input int window_size);
    return window_size / 2;
  endfunction
  function automatic int cnt_width(input int line_width);
    return $clog2(line_width + 1);
  endfunction
endpackage

// File: rtl/pixel_line_ram.sv
// pixel_line_ram: one-line pixel store with a write port and a registered read port.
module pixel_line_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/median_line_feeder.sv
// median_line_feeder: buffers one line and replays it as a gap-free, edge-padded burst.
// MEDIAN_FEEDER_PINGPONG_EN adds a second bank so filling overlaps emission.
module median_line_feeder
  import median_pkg::*;
#(
  parameter int DATA_WIDTH  = MEDIAN_DATA_WIDTH,
  parameter int LINE_WIDTH  = 640,
  parameter int WINDOW_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  pix_valid,
  output logic                  pix_pad,
  output logic                  pix_sol,
  output logic                  pix_eol,
  output logic                  err_overflow
);
  localparam int CW = cnt_width(LINE_WIDTH);
  localparam int AW = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0] HM1  = CW'(halo(WINDOW_SIZE) - 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WIDTH - 1);
`ifdef MEDIAN_FEEDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  feeder_state_t r_st, w_st_n;
  logic [CW-1:0] r_wr_cnt, r_rd_cnt, w_rd_cnt_n, w_len, w_raddr;
  logic [CW-1:0] r_len [NB];
  logic [NB-1:0] r_full, w_full_n;
  logic [DATA_WIDTH-1:0] w_q [NB];
  logic r_wb, r_rb, r_rb1, w_wb_n, w_rb_n, w_next_rdy, w_ready_n;
  logic w_xfer, w_end, w_done, w_v0;
  logic r_v1, r_pad1, r_sol1, r_eol1;
  assign w_xfer  = s_valid & s_ready;
  assign w_end   = w_xfer & (s_last | (r_wr_cnt == LAST));
  assign w_len   = r_len[r_rb];
  assign w_done  = r_st == POST && r_rd_cnt == HM1;
  assign w_v0    = r_st != FILL;
  assign w_raddr = r_st == BODY ? r_rd_cnt : r_st == POST ? w_len - 1'b1 : '0;
`ifdef MEDIAN_FEEDER_PINGPONG_EN
  assign w_wb_n     = r_wb ^ w_end;
  assign w_rb_n     = r_rb ^ w_done;
  assign w_next_rdy = r_full[~r_rb] | (w_end & (r_wb != r_rb));
  assign w_ready_n  = !w_full_n[w_wb_n];
`else
  assign w_wb_n     = 1'b0;
  assign w_rb_n     = 1'b0;
  assign w_next_rdy = 1'b0;
  // hold off the next line until the output pipeline has drained the burst
  assign w_ready_n  = w_st_n == FILL && r_st == FILL && !r_v1;
`endif
  always_comb begin
    w_full_n = r_full;
    if (w_done) w_full_n[r_rb] = 1'b0;
    if (w_end) w_full_n[r_wb] = 1'b1;
  end
  always_comb begin
    w_st_n     = r_st;
    w_rd_cnt_n = r_rd_cnt + 1'b1;
    case (r_st)
      FILL: begin
        w_rd_cnt_n = '0;
        if (w_end || r_full[r_rb]) w_st_n = PRE;
      end
      PRE: if (r_rd_cnt == HM1) begin
        w_st_n     = BODY;
        w_rd_cnt_n = '0;
      end
      BODY: if (r_rd_cnt == w_len - 1'b1) begin
        w_st_n     = POST;
        w_rd_cnt_n = '0;
      end
      default: if (w_done) begin
        w_st_n     = w_next_rdy ? PRE : FILL;
        w_rd_cnt_n = '0;
      end
    endcase
  end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    pixel_line_ram #(.DW(DATA_WIDTH), .DEPTH(LINE_WIDTH)) u_ram (
      .clk     (clk),
      .i_we    (w_xfer && r_wb == 1'(b)),
      .i_waddr (r_wr_cnt[AW-1:0]),
      .i_wdata (s_pixel),
      .i_raddr (w_raddr[AW-1:0]),
      .o_rdata (w_q[b])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st         <= FILL;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_full       <= '0;
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_rb1        <= 1'b0;
      {r_v1, r_pad1, r_sol1, r_eol1} <= '0;
      {pix_valid, pix_pad, pix_sol, pix_eol} <= '0;
      pix_out      <= '0;
      s_ready      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      r_st         <= w_st_n;
      r_rd_cnt     <= w_rd_cnt_n;
      r_full       <= w_full_n;
      r_wb         <= w_wb_n;
      r_rb         <= w_rb_n;
      r_rb1        <= r_rb;
      r_wr_cnt     <= w_end ? '0 : w_xfer ? r_wr_cnt + 1'b1 : r_wr_cnt;
      if (w_end) r_len[r_wb] <= r_wr_cnt + 1'b1;
      err_overflow <= err_overflow | (w_end & !s_last);
      // flags ride one stage behind the state so they line up with RAM read data
      r_v1         <= w_v0;
      r_pad1       <= r_st == PRE || r_st == POST;
      r_sol1       <= r_st == PRE && r_rd_cnt == '0;
      r_eol1       <= w_done;
      pix_valid    <= r_v1;
      pix_pad      <= r_pad1;
      pix_sol      <= r_sol1;
      pix_eol      <= r_eol1;
      pix_out      <= r_v1 ? w_q[r_rb1] : pix_out;
      s_ready      <= w_ready_n;
    end
  end
endmodule

// File: tb/tb_median_line_feeder.sv
// tb_median_line_feeder: directed and randomized checks of median_line_feeder against a line-level burst model.
module tb_median_line_feeder;
  localparam int LW = 4;
  localparam int WS = 3;
  localparam int H  = WS / 2;
  typedef struct { int t; logic [7:0] p; logic pad; logic sol; logic eol; } item_t;
  logic clk = 1'b0, rst = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0] s_pixel = '0;
  logic s_ready, pix_valid, pix_pad, pix_sol, pix_eol, err_overflow;
  logic [7:0] pix_out;
  int vectors = 0, errors = 0, e = 0, rdy_at = 0, last_end = 0;
  int obs_n = 0, run = 0, max_run = 0, ready_low = 0, len = 0;
  logic [127:0] obs_word = '0;
  logic [31:0] obs_pad = '0, obs_sol = '0, obs_eol = '0;
  logic did = 1'b0, err_exp = 1'b0;
  logic [7:0] last_pix = '0;
  item_t q[$];
  logic [7:0] cur[$];

  always #5 clk = ~clk;

  median_line_feeder #(.DATA_WIDTH(8), .LINE_WIDTH(LW), .WINDOW_SIZE(WS)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .pix_out(pix_out), .pix_valid(pix_valid), .pix_pad(pix_pad),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .err_overflow(err_overflow)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // one clock: drive inputs, advance the model on the edge, compare outputs 1 time unit later
  task automatic step(input logic v, input logic [7:0] p, input logic l, input logic r);
    int start;
    int k;
    item_t it;
    logic ev, ep, es, ee;
    s_valid = v; s_pixel = p; s_last = l; rst = r;
    did = r && v && (s_ready === 1'b1);
    @(posedge clk);
    e++;
    if (!r) begin
      q.delete(); cur.delete();
      last_pix = '0; err_exp = 1'b0; rdy_at = e + 1; last_end = e;
    end else if (did) begin
      cur.push_back(p);
      if (l || cur.size() == LW) begin
        if (!l) err_exp = 1'b1;
        start = (e + 2 > last_end + 1) ? e + 2 : last_end + 1;
        for (int i = 0; i < cur.size() + 2 * H; i++) begin
          k = i - H;
          if (k < 0) k = 0;
          if (k > cur.size() - 1) k = cur.size() - 1;
          q.push_back('{start + i, cur[k], (i < H) || (i >= H + cur.size()), i == 0, i == cur.size() + 2 * H - 1});
        end
        last_end = start + cur.size() + 2 * H - 1;
        rdy_at = last_end + 1;
        cur.delete();
      end
    end
    #1;
    {ev, ep, es, ee} = '0;
    if (q.size() > 0 && q[0].t == e) begin
      it = q.pop_front();
      ev = 1'b1; ep = it.pad; es = it.sol; ee = it.eol; last_pix = it.p;
    end
    chk("pix_valid", pix_valid, ev);
    chk("pix_pad", pix_pad, ep);
    chk("pix_sol", pix_sol, es);
    chk("pix_eol", pix_eol, ee);
    chk("pix_out", pix_out, last_pix);
    chk("err_overflow", err_overflow, err_exp);
`ifndef MEDIAN_FEEDER_PINGPONG_EN
    chk("s_ready", s_ready, e >= rdy_at);
`endif
    if (r && s_ready !== 1'b1) ready_low++;
    if (pix_valid === 1'b1) begin
      obs_word = (obs_word << 8) | 128'(pix_out);
      obs_pad = {obs_pad[30:0], pix_pad};
      obs_sol = {obs_sol[30:0], pix_sol};
      obs_eol = {obs_eol[30:0], pix_eol};
      obs_n++; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic send(input logic [7:0] p, input logic l, input int gap);
    int n;
    n = 0;
    idle(gap);
    do begin
      step(1'b1, p, l, 1'b1);
      n++;
    end while (!did && n < 64);
    if (!did) chk("handshake_timeout", 0, 1);
  endtask

  task automatic clear_obs();
    obs_word = '0; obs_pad = '0; obs_sol = '0; obs_eol = '0;
    obs_n = 0; run = 0; max_run = 0;
  endtask

  task automatic check_obs(input string tag, input int n, input logic [127:0] w,
                           input logic [31:0] pad, input logic [31:0] sol, input logic [31:0] eol);
    chk({tag, "_count"}, obs_n, n);
    chk({tag, "_contiguous"}, max_run, n);
    chk({tag, "_pixels"}, obs_word, w);
    chk({tag, "_pad"}, obs_pad, pad);
    chk({tag, "_sol"}, obs_sol, sol);
    chk({tag, "_eol"}, obs_eol, eol);
  endtask

  initial begin
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    chk("reset_ready", s_ready, 0);
    chk("reset_valid", pix_valid, 0);
    chk("reset_pix", pix_out, 0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("ready_after_reset", s_ready, 1);

    clear_obs();
    send(8'd10, 1'b0, 0); send(8'd20, 1'b0, 0); send(8'd30, 1'b0, 0); send(8'd40, 1'b1, 0);
    idle(10);
    check_obs("burst4", 6, 128'h0a0a141e2828, 32'b100001, 32'b100000, 32'b000001);
    chk("no_overflow", err_overflow, 0);

    clear_obs();
    send(8'd55, 1'b1, 0);
    idle(8);
    check_obs("single", 3, 128'h373737, 32'b101, 32'b100, 32'b001);

    clear_obs();
    send(8'd1, 1'b0, 0); send(8'd2, 1'b0, 0); send(8'd3, 1'b0, 0); send(8'd4, 1'b0, 0);
    idle(10);
    check_obs("overflow", 6, 128'h010102030404, 32'b100001, 32'b100000, 32'b000001);
    chk("overflow_flag", err_overflow, 1);
    clear_obs();
    send(8'd5, 1'b0, 0); send(8'd6, 1'b1, 0);
    idle(8);
    check_obs("overflow_tail", 4, 128'h05050606, 32'b1001, 32'b1000, 32'b0001);
    chk("overflow_sticky", err_overflow, 1);

    clear_obs();
    send(8'd3, 1'b0, 1); send(8'd9, 1'b0, 1); send(8'd27, 1'b0, 1); send(8'd81, 1'b1, 1);
    idle(10);
    check_obs("toggle", 6, 128'h030309_1b5151, 32'b100001, 32'b100000, 32'b000001);

    send(8'd1, 1'b0, 0); send(8'd2, 1'b0, 0); send(8'd3, 1'b0, 0); send(8'd4, 1'b1, 0);
    idle(2);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("midbody_rst_valid", pix_valid, 0);
    chk("midbody_rst_pix", pix_out, 0);
    chk("midbody_rst_ready", s_ready, 0);
    chk("midbody_rst_err", err_overflow, 0);
    clear_obs();
    step(1'b0, 8'd0, 1'b0, 1'b1);
    send(8'd7, 1'b0, 0); send(8'd8, 1'b1, 0);
    idle(8);
    check_obs("after_rst", 4, 128'h07070808, 32'b1001, 32'b1000, 32'b0001);

`ifdef MEDIAN_FEEDER_PINGPONG_EN
    clear_obs();
    ready_low = 0;
    for (int i = 0; i < 8; i++) send(8'(i + 1), i == 3 || i == 7, 0);
    idle(14);
    chk("pp_ready_held", ready_low, 0);
    check_obs("pp_b2b", 12, 128'h010102030404_050506070808,
              32'b100001100001, 32'b100000100000, 32'b000001000001);
`endif

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
    end
    idle(20);
    chk("model_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
